// File: rtl/keyvalue_wb_initiator.sv
// Wishbone classic single-beat initiator for the key/value store.
// Turns one put/get command into one bus cycle with timeout and returns a response.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | cmd_ready high, waiting for a command
// BUS   | CYC/STB asserted, waiting for ACK, ERR or timeout
// RESP  | response held on rsp_* until the client takes it
module keyvalue_wb_initiator #(
    parameter int unsigned KEY_W     = 8,
    parameter int unsigned DATA_W    = 32,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [KEY_W-1:0]  cmd_key,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              CYC_o,
    output logic              STB_o,
    output logic              WE_o,
    output logic [3:0]        SEL_o,
    output logic [31:0]       ADR_o,
    output logic [DATA_W-1:0] DAT_o,
    input  logic [DATA_W-1:0] DAT_i,
    input  logic              ACK_i,
    input  logic              ERR_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Down-counter loaded with TIMEOUT-1; reaching zero in BUS means the
    // TIMEOUT-th bus cycle has elapsed without a slave answer.
    localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT - 1);

    state_t      state_q;
    state_t      state_d;
    logic [15:0] tmo_q;
    logic [31:0] adr_calc;
    logic        accept;
    logic        term_err;
    logic        term_ack;
    logic        term_tmo;
    logic        term_any;
    logic        rsp_done;

    always_comb begin
        adr_calc = BASE_ADDR + 32'({cmd_key, 2'b00});
        accept   = (state_q == ST_IDLE) && cmd_valid;
        term_err = (state_q == ST_BUS) && ERR_i;
        term_ack = (state_q == ST_BUS) && !ERR_i && ACK_i;
        term_tmo = (state_q == ST_BUS) && !ERR_i && !ACK_i && (tmo_q == 16'd0);
        term_any = term_err || term_ack || term_tmo;
        rsp_done = (state_q == ST_RESP) && rsp_ready;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)   state_d = ST_BUS;
            ST_BUS:  if (term_any) state_d = ST_RESP;
            ST_RESP: if (rsp_done) state_d = ST_IDLE;
            default:               state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == ST_IDLE);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            CYC_o <= 1'b0;
            STB_o <= 1'b0;
            WE_o  <= 1'b0;
            SEL_o <= 4'h0;
            ADR_o <= 32'h0;
            DAT_o <= '0;
        end else if (accept) begin
            CYC_o <= 1'b1;
            STB_o <= 1'b1;
            WE_o  <= cmd_we;
            SEL_o <= 4'hF;
            ADR_o <= adr_calc;
            DAT_o <= cmd_we ? cmd_data : '0;
        end else if (term_any) begin
            // ADR_o is left as-is; only the qualifying strobes and data drop.
            CYC_o <= 1'b0;
            STB_o <= 1'b0;
            WE_o  <= 1'b0;
            SEL_o <= 4'h0;
            DAT_o <= '0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tmo_q <= 16'd0;
        end else if (accept) begin
            tmo_q <= TMO_LOAD;
        end else if ((state_q == ST_BUS) && !term_any) begin
            tmo_q <= tmo_q - 16'd1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
        end else if (term_ack) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_data  <= WE_o ? DAT_o : DAT_i;
        end else if (term_err || term_tmo) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_data  <= '0;
        end else if (rsp_done) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule
